// File: rtl/icache_responder_pkg.sv
// rtl/icache_responder_pkg.sv - shared data width, state encodings and helpers for the instruction cache
package icache_responder_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [0:0] {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_t;

    // Word-offset fields stay at least one bit wide so single-word lines still elaborate.
    function automatic int off_width(input int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// rtl/icache_data_array.sv - valid/tag/data storage with one combinational read port and one write port
module icache_data_array
    import icache_responder_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int LINE_WORDS = 4,
    parameter int TAG_BITS   = 23,
    parameter int OFF_W      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [OFF_W-1:0]      rd_offset,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output data_t                 rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [OFF_W-1:0]      wr_offset,
    input  data_t                 wr_data,
    input  logic                  tag_wr_en,
    input  logic [TAG_BITS-1:0]   wr_tag
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int OFF_BITS = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
    localparam int WADDR_W  = INDEX_BITS + OFF_BITS;
    localparam int WORDS    = LINES * LINE_WORDS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    data_t               data_mem [WORDS];

    logic [WADDR_W-1:0] rd_addr;
    logic [WADDR_W-1:0] wr_addr;

    // With single-word lines the padding offset bit is shifted out of the word address.
    assign rd_addr = WADDR_W'({rd_index, rd_offset} >> (OFF_W - OFF_BITS));
    assign wr_addr = WADDR_W'({wr_index, wr_offset} >> (OFF_W - OFF_BITS));

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_addr] <= wr_data;
        end
        if (tag_wr_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (tag_wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped instruction cache, word-serial refill; ICACHE_CRITICAL_WORD_EN enables critical-word-first
module icache_responder
    import icache_responder_pkg::*;
#(
    parameter int INDEX_BITS = 5,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        valid_from_if,
    input  logic [31:0] pc_from_if,
    output logic        valid_to_if,
    output logic [31:0] inst_to_if,
    input  logic        rollback,
    output logic        valid_to_mem,
    output logic [31:0] addr_to_mem,
    input  logic        valid_from_mem,
    input  logic [31:0] data_from_mem
);

    localparam int OFF_BITS = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 0;
    localparam int OFF_W    = off_width(LINE_WORDS);
    localparam int OB       = 2 + OFF_BITS;
    localparam int TAG_BITS = DATA_WIDTH - OB - INDEX_BITS;
    localparam logic [OFF_W-1:0] OFF_MASK  = OFF_W'(LINE_WORDS - 1);
    localparam data_t            LINE_MASK = data_t'((1 << OB) - 1);

    function automatic logic [OFF_W-1:0] pc_offset(input data_t pc);
        return OFF_W'(pc >> 2) & OFF_MASK;
    endfunction

    icache_state_t state_q, state_d;

    data_t            pc_q, pc_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             block_q, block_d;
    logic             valid_to_if_q, valid_to_if_d;
    data_t            inst_q, inst_d;
    logic             valid_to_mem_q, valid_to_mem_d;
    data_t            addr_q, addr_d;

    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [OFF_W-1:0]      req_start;
    logic [OFF_W-1:0]      start_q;
    logic [OFF_W-1:0]      cnt_next;
    data_t                 line_base;

    logic                rd_valid;
    logic [TAG_BITS-1:0] rd_tag;
    data_t               rd_data;

    logic hit, accept, ack, last;

    assign req_index = pc_from_if[OB +: INDEX_BITS];
    assign req_tag   = pc_from_if[DATA_WIDTH-1 -: TAG_BITS];
    assign line_base = pc_q & ~LINE_MASK;
    assign cnt_next  = OFF_W'(cnt_q + 1'b1) & OFF_MASK;

`ifdef ICACHE_CRITICAL_WORD_EN
    assign req_start = pc_offset(pc_from_if);
    assign start_q   = pc_offset(pc_q);
`else
    assign req_start = '0;
    assign start_q   = '0;
`endif

    assign hit    = rd_valid && (rd_tag == req_tag);
    assign accept = rdy && (state_q == ICACHE_IDLE) && valid_from_if
                    && !valid_to_if_q && !rollback && !block_q;
    assign ack    = rdy && !rst && (state_q == ICACHE_REFILL) && valid_from_mem;
    // The counter walks the line from its start word; arriving back there means the line is full.
    assign last   = (cnt_next == start_q);

    icache_data_array #(
        .INDEX_BITS (INDEX_BITS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_BITS),
        .OFF_W      (OFF_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (req_index),
        .rd_offset (pc_offset(pc_from_if)),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_en     (ack),
        .wr_index  (pc_q[OB +: INDEX_BITS]),
        .wr_offset (cnt_q),
        .wr_data   (data_from_mem),
        .tag_wr_en (ack && last),
        .wr_tag    (pc_q[DATA_WIDTH-1 -: TAG_BITS])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ICACHE_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ICACHE_IDLE:   if (accept && !hit) state_d = ICACHE_REFILL;
            ICACHE_REFILL: if (ack && last)    state_d = ICACHE_IDLE;
            default:       state_d = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        valid_to_if_d  = 1'b0;
        inst_d         = inst_q;
        valid_to_mem_d = valid_to_mem_q;
        addr_d         = addr_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        drop_d         = drop_q;
        block_d        = block_q;
        case (state_q)
            ICACHE_IDLE: begin
                drop_d  = 1'b0;
                block_d = 1'b0;
                if (accept) begin
                    if (hit) begin
                        valid_to_if_d = 1'b1;
                        inst_d        = rd_data;
                    end else begin
                        pc_d           = pc_from_if;
                        cnt_d          = req_start;
                        valid_to_mem_d = 1'b1;
                        addr_d         = (pc_from_if & ~LINE_MASK) | (data_t'(req_start) << 2);
                    end
                end
            end
            ICACHE_REFILL: begin
                if (rollback) begin
                    drop_d = 1'b1;
                end
                if (ack) begin
                    cnt_d  = cnt_next;
                    addr_d = line_base | (data_t'(cnt_next) << 2);
`ifdef ICACHE_CRITICAL_WORD_EN
                    if ((cnt_q == start_q) && !drop_q && !rollback) begin
                        valid_to_if_d = 1'b1;
                        inst_d        = data_from_mem;
                        block_d       = 1'b1;
                    end
`endif
                    if (last) begin
                        valid_to_mem_d = 1'b0;
                        drop_d         = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= '0;
            cnt_q          <= '0;
            drop_q         <= 1'b0;
            block_q        <= 1'b0;
            valid_to_if_q  <= 1'b0;
            inst_q         <= '0;
            valid_to_mem_q <= 1'b0;
            addr_q         <= '0;
        end else if (rdy) begin
            pc_q           <= pc_d;
            cnt_q          <= cnt_d;
            drop_q         <= drop_d;
            block_q        <= block_d;
            valid_to_if_q  <= valid_to_if_d;
            inst_q         <= inst_d;
            valid_to_mem_q <= valid_to_mem_d;
            addr_q         <= addr_d;
        end
    end

    // A rollback squashes a response already sitting in the output register.
    assign valid_to_if  = valid_to_if_q && !rollback;
    assign inst_to_if   = inst_q;
    assign valid_to_mem = valid_to_mem_q;
    assign addr_to_mem  = addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - directed scoreboard bench for icache_responder; ICACHE_CRITICAL_WORD_EN selects critical-word expectations
module tb_icache_responder;

    logic        clk = 1'b0;
    logic        rst, rdy, valid_from_if, rollback, valid_from_mem;
    logic [31:0] pc_from_if, data_from_mem;
    logic        valid_to_if, valid_to_mem;
    logic [31:0] inst_to_if, addr_to_mem;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n_resp      = 0;
    int resp_cycle  = 0;
    int crit_ack    = 0;
    int last_ack    = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    icache_responder #(.INDEX_BITS(5), .LINE_WORDS(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .valid_from_if  (valid_from_if),
        .pc_from_if     (pc_from_if),
        .valid_to_if    (valid_to_if),
        .inst_to_if     (inst_to_if),
        .rollback       (rollback),
        .valid_to_mem   (valid_to_mem),
        .addr_to_mem    (addr_to_mem),
        .valid_from_mem (valid_from_mem),
        .data_from_mem  (data_from_mem)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a & 32'hFFFF_FFF0) + (((a >> 2) & 32'd3) + 32'd1) * 32'h11;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && valid_to_if) begin
            n_resp++;
            resp_cycle = cyc;
            chk("resp_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) chk("inst", inst_to_if, exp_q.pop_front());
        end
    end

    task automatic serve(input logic [31:0] pc, input int rb_word, input int freeze_word);
        logic [31:0] base;
        logic [31:0] a;
        int start;
        base = pc & 32'hFFFF_FFF0;
`ifdef ICACHE_CRITICAL_WORD_EN
        start = int'((pc >> 2) & 32'd3);
`else
        start = 0;
`endif
        for (int w = 0; w < 4; w++) begin
            a = base | 32'(((start + w) % 4) * 4);
            if (w == freeze_word) begin
                rdy = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    chk("freeze_vmem", 32'(valid_to_mem), 32'd1);
                    chk("freeze_addr", addr_to_mem, a);
                end
                rdy = 1'b1;
            end
            chk("mem_valid", 32'(valid_to_mem), 32'd1);
            chk("mem_addr", addr_to_mem, a);
            valid_from_mem = 1'b1;
            data_from_mem  = mem_word(a);
            rollback       = (w == rb_word);
            if (w == 0) crit_ack = cyc;
            last_ack = cyc;
            tick();
            valid_from_mem = 1'b0;
            rollback       = 1'b0;
            if (w == rb_word) valid_from_if = 1'b0;
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input bit miss, input int freeze_word);
        int n0;
        int req;
        int k;
        n0 = n_resp;
        exp_q.push_back(mem_word(pc));
        pc_from_if    = pc;
        valid_from_if = 1'b1;
        req = cyc;
        tick();
        if (miss) serve(pc, -1, freeze_word);
        else      chk("hit_no_mem", 32'(valid_to_mem), 32'd0);
        k = 0;
        while (n_resp == n0 && !valid_to_if && k < 20) begin
            tick();
            k++;
        end
        tick();
        valid_from_if = 1'b0;
        tick();
        tick();
        chk("resp_count", 32'(n_resp - n0), 32'd1);
        chk("mem_idle", 32'(valid_to_mem), 32'd0);
        if (!miss)
            chk("hit_latency", 32'(resp_cycle - req), 32'd1);
        else begin
`ifdef ICACHE_CRITICAL_WORD_EN
            chk("crit_latency", 32'(resp_cycle - crit_ack), 32'd1);
`else
            chk("miss_latency", 32'(resp_cycle - last_ack), 32'd2);
`endif
        end
    endtask

    initial begin
        int n0;
        rst = 1'b1; rdy = 1'b1; valid_from_if = 1'b0; pc_from_if = '0;
        rollback = 1'b0; valid_from_mem = 1'b0; data_from_mem = '0;
        tick();
        tick();
        chk("rst_valid_to_if", 32'(valid_to_if), 32'd0);
        chk("rst_inst", inst_to_if, 32'd0);
        chk("rst_vmem", 32'(valid_to_mem), 32'd0);
        chk("rst_addr", addr_to_mem, 32'd0);
        rst = 1'b0;
        tick();

        fetch(32'h0, 1'b1, -1);
        fetch(32'h8, 1'b0, -1);
        fetch(32'h200, 1'b1, -1);
        fetch(32'h4, 1'b1, -1);

        n0 = n_resp;
        pc_from_if = 32'hC; valid_from_if = 1'b1; rollback = 1'b1;
        tick();
        rollback = 1'b0; valid_from_if = 1'b0;
        #1;
        chk("rb_hit_blocked", 32'(valid_to_if), 32'd0);
        tick();
        tick();
        chk("rb_hit_count", 32'(n_resp - n0), 32'd0);

        n0 = n_resp;
        pc_from_if = 32'h40; valid_from_if = 1'b1;
        tick();
        serve(32'h40, 1, -1);
        repeat (4) tick();
        chk("rb_refill_noresp", 32'(n_resp - n0), 32'd0);
        chk("rb_refill_vmem", 32'(valid_to_mem), 32'd0);
        fetch(32'h40, 1'b0, -1);

        fetch(32'h80, 1'b1, 2);

        pc_from_if = 32'hC0; valid_from_if = 1'b1;
        tick();
        chk("pre_rst_vmem", 32'(valid_to_mem), 32'd1);
        rst = 1'b1; valid_from_if = 1'b0;
        tick();
        chk("mid_rst_vmem", 32'(valid_to_mem), 32'd0);
        chk("mid_rst_addr", addr_to_mem, 32'd0);
        rst = 1'b0;
        tick();

        fetch(32'h8, 1'b1, -1);
        fetch(32'hC, 1'b0, -1);
        fetch(32'hC0, 1'b1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
